e_spigot_core: RTL and testbench

Streaming digit generator for the constant e, using the Rabinowitz–Wagon spigot over a mixed-radix remainder array. It sits directly upstream of the four-digit output wrapper. It emits one decimal digit at a time (2, 7, 1, 8, …) over a valid/ready handshake. It uses a fixed 5-cycle restoring-division step per array element.

---
 rtl/spigot_pkg.sv | 26 ++
 rtl/spigot_divstep.sv | 29 ++
 rtl/e_spigot_core.sv | 211 +++++++++++++++++++++
 tb/tb_e_spigot_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spigot_pkg.sv
// Shared definitions for the e spigot digit generator: FSM state encoding,
// width helpers for the remainder array and working register, and the
// integer part of e that is emitted before any array work is done.
package spigot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    LOAD = 3'd2,
    DIV  = 3'd3,
    DONE = 3'd4
  } spigot_state_e;

  localparam logic [3:0] INT_DIGIT = 4'd2;

  // Width of one remainder a[k]; a[k] < k <= n_terms.
  function automatic int calc_aw(input int n_terms);
    return $clog2(n_terms + 32'sd1);
  endfunction

  // Width of the working register x; x <= 10*k - 1.
  function automatic int calc_xw(input int n_terms);
    return $clog2(n_terms * 32'sd10);
  endfunction

endpackage

// File: rtl/spigot_divstep.sv
// One restoring-division step: compares x against k shifted left by b and
// subtracts when it fits. Purely combinational; the core reuses the single
// instance across the four quotient-bit cycles.
module spigot_divstep #(
  parameter int AW = 6,
  parameter int XW = 9
) (
  input  logic [XW-1:0] x,
  input  logic [AW-1:0] k,
  input  logic [1:0]    b,
  output logic [XW-1:0] x_new,
  output logic          q_bit
);

  logic [XW-1:0] shifted_s;

  // Trial subtraction of k << b; 8k always fits in XW bits since 8k < 10k.
  always_comb begin
    shifted_s = XW'(k) << b;
    if (x >= shifted_s) begin
      x_new = x - shifted_s;
      q_bit = 1'b1;
    end else begin
      x_new = x;
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/e_spigot_core.sv
// Streaming generator for the decimal digits of e (Rabinowitz-Wagon spigot).
// Each digit sweeps the mixed-radix remainder array from k = N_TERMS down to
// k = 2; every element costs one LOAD cycle plus four restoring-division
// cycles. Digits leave over a valid/ready handshake with all outputs taken
// straight from flops.
// Optional feature macro: SPIGOT_DIGIT_WINDOW_EN adds a 16-bit `window` output
// holding the four most recently accepted digits (newest in [3:0]).
module e_spigot_core
  import spigot_pkg::*;
#(
  parameter int N_TERMS    = 32,
  parameter int MAX_DIGITS = 25,
  localparam int CW        = $clog2(MAX_DIGITS + 32'sd1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          digit_ready,
  output logic          digit_valid,
  output logic [3:0]    digit,
  output logic [CW-1:0] digit_count,
`ifdef SPIGOT_DIGIT_WINDOW_EN
  output logic [15:0]   window,
`endif
  output logic          done
);

  localparam int AW = calc_aw(N_TERMS);
  localparam int XW = calc_xw(N_TERMS);

  spigot_state_e state_r, state_nxt_s;

  logic [AW-1:0] a_r [N_TERMS+1];
  logic [AW-1:0] a_rd_s;
  logic          a_we_s;

  logic [AW-1:0] k_r, k_nxt_s;
  logic [3:0]    carry_r, carry_nxt_s;
  logic [3:0]    q_r, q_nxt_s, q_set_s;
  logic [XW-1:0] x_r, x_nxt_s, x_load_s, div_x_s;
  logic [1:0]    b_r, b_nxt_s;
  logic          div_q_s;

  logic [3:0]    digit_r, digit_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          done_r, done_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s, count_inc_s;

`ifdef SPIGOT_DIGIT_WINDOW_EN
  logic [15:0]   window_r, window_nxt_s;
`endif

  spigot_divstep #(
    .AW (AW),
    .XW (XW)
  ) u_divstep (
    .x     (x_r),
    .k     (k_r),
    .b     (b_r),
    .x_new (div_x_s),
    .q_bit (div_q_s)
  );

  // Next-state and datapath decode; ena low leaves every default (hold) in place.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    carry_nxt_s = carry_r;
    q_nxt_s     = q_r;
    x_nxt_s     = x_r;
    b_nxt_s     = b_r;
    digit_nxt_s = digit_r;
    valid_nxt_s = valid_r;
    done_nxt_s  = done_r;
    count_nxt_s = count_r;
    a_we_s      = 1'b0;
    a_rd_s      = a_r[k_r];
    x_load_s    = XW'(a_rd_s) * XW'(4'd10) + XW'(carry_r);
    count_inc_s = count_r + CW'(1'b1);
    q_set_s     = q_r;
    q_set_s[b_r] = div_q_s;
`ifdef SPIGOT_DIGIT_WINDOW_EN
    window_nxt_s = window_r;
`endif
    if (ena) begin
      case (state_r)
        IDLE: begin
          digit_nxt_s = INT_DIGIT;
          valid_nxt_s = 1'b1;
          state_nxt_s = HOLD;
        end
        HOLD: begin
          if (digit_ready) begin
            valid_nxt_s = 1'b0;
            count_nxt_s = count_inc_s;
`ifdef SPIGOT_DIGIT_WINDOW_EN
            window_nxt_s = {window_r[11:0], digit_r};
`endif
            if (count_inc_s == CW'(MAX_DIGITS)) begin
              done_nxt_s  = 1'b1;
              state_nxt_s = DONE;
            end else begin
              k_nxt_s     = AW'(N_TERMS);
              carry_nxt_s = 4'd0;
              state_nxt_s = LOAD;
            end
          end else begin
            state_nxt_s = HOLD;
          end
        end
        LOAD: begin
          x_nxt_s     = x_load_s;
          q_nxt_s     = 4'd0;
          b_nxt_s     = 2'd3;
          state_nxt_s = DIV;
        end
        DIV: begin
          x_nxt_s = div_x_s;
          q_nxt_s = q_set_s;
          if (b_r == 2'd0) begin
            a_we_s      = 1'b1;
            carry_nxt_s = q_set_s;
            if (k_r == AW'(2'd2)) begin
              digit_nxt_s = q_set_s;
              valid_nxt_s = 1'b1;
              state_nxt_s = HOLD;
            end else begin
              k_nxt_s     = k_r - AW'(1'b1);
              state_nxt_s = LOAD;
            end
          end else begin
            b_nxt_s = b_r - 2'd1;
          end
        end
        DONE: begin
          done_nxt_s  = 1'b1;
          valid_nxt_s = 1'b0;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_r     <= '0;
      carry_r <= 4'd0;
      q_r     <= 4'd0;
      x_r     <= '0;
      b_r     <= 2'd0;
      digit_r <= 4'd0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      count_r <= '0;
    end else begin
      k_r     <= k_nxt_s;
      carry_r <= carry_nxt_s;
      q_r     <= q_nxt_s;
      x_r     <= x_nxt_s;
      b_r     <= b_nxt_s;
      digit_r <= digit_nxt_s;
      valid_r <= valid_nxt_s;
      done_r  <= done_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Remainder array; every term restarts at 1 so the series sums to e - 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= N_TERMS; i++) begin
        a_r[i] <= AW'(1'b1);
      end
    end else if (a_we_s) begin
      a_r[k_r] <= div_x_s[AW-1:0];
    end
  end

`ifdef SPIGOT_DIGIT_WINDOW_EN
  // Shift register of the last four accepted digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      window_r <= 16'h0000;
    end else begin
      window_r <= window_nxt_s;
    end
  end

  assign window = window_r;
`endif

  assign digit_valid = valid_r;
  assign digit       = digit_r;
  assign digit_count = count_r;
  assign done        = done_r;

endmodule

// File: tb/tb_e_spigot_core.sv
// Self-checking bench for e_spigot_core: a table of the first 25 digits of e
// with their expected latencies, hand-written ena-drop and mid-row reset
// sequences, and a randomized ena/ready run scored against a plain integer
// spigot model.
module tb_e_spigot_core;

  localparam int N_TERMS    = 32;
  localparam int MAX_DIGITS = 25;
  localparam int ROW_LAT    = 5 * (N_TERMS - 1);

  logic       clk;
  logic       reset;
  logic       ena;
  logic       digit_ready;
  logic       digit_valid;
  logic [3:0] digit;
  logic [4:0] digit_count;
  logic       done;
`ifdef SPIGOT_DIGIT_WINDOW_EN
  logic [15:0] window;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int digit;
    int lat;
    int hold;
  } vec_t;

  vec_t tbl[MAX_DIGITS];
  int   exp_seq[MAX_DIGITS] = '{2,7,1,8,2,8,1,8,2,8,4,5,9,0,4,5,2,3,5,3,6,0,2,8,7};
  int   model[MAX_DIGITS];

  e_spigot_core #(
    .N_TERMS    (N_TERMS),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .digit_ready (digit_ready),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_count (digit_count),
`ifdef SPIGOT_DIGIT_WINDOW_EN
    .window      (window),
`endif
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ena = 1'b0;
    digit_ready = 1'b0;
    repeat (3) tick();
    chk("reset_valid", int'(digit_valid), 0);
    chk("reset_digit", int'(digit), 0);
    chk("reset_count", int'(digit_count), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    ena = 1'b1;
    digit_ready = 1'b1;
  endtask

  // Count edges until digit_valid is seen; bounded.
  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (cyc < 2000 && !ok) begin
      tick();
      cyc++;
      if (digit_valid) ok = 1'b1;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  // Accept the currently valid digit on the next edge.
  task automatic accept(input int exp_count);
    digit_ready = 1'b1;
    tick();
    chk("accept_valid_drop", int'(digit_valid), 0);
    chk("accept_count", int'(digit_count), exp_count);
  endtask

  task automatic get_digit(input int exp_digit, input int exp_lat, input int hold, input int exp_count);
    int cyc;
    bit ok;
    wait_valid(cyc, ok);
    if (ok) begin
      chk("latency", cyc, exp_lat);
      chk("digit", int'(digit), exp_digit);
      if (hold > 0) begin
        digit_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
          tick();
          chk("hold_valid", int'(digit_valid), 1);
          chk("hold_digit", int'(digit), exp_digit);
          chk("hold_count", int'(digit_count), exp_count - 1);
        end
      end
      accept(exp_count);
    end
  endtask

  initial begin
    int cyc, c2, idx, since;
    bit ok, vprev, done_seen, e_v, r_v;
    int dprev;
    int a_m[N_TERMS+1];
    int carry_m, x_m;

    // Reference digits of e from the mixed-radix series, plain integer arithmetic.
    for (int k = 0; k <= N_TERMS; k++) a_m[k] = 1;
    model[0] = 2;
    for (int i = 1; i < MAX_DIGITS; i++) begin
      carry_m = 0;
      for (int k = N_TERMS; k >= 2; k--) begin
        x_m = 10 * a_m[k] + carry_m;
        a_m[k] = x_m % k;
        carry_m = x_m / k;
      end
      model[i] = carry_m;
    end

    for (int i = 0; i < MAX_DIGITS; i++) begin
      tbl[i].digit = exp_seq[i];
      tbl[i].lat   = (i == 0) ? 1 : ROW_LAT;
      tbl[i].hold  = (i == 1) ? 50 : 0;
    end

    // Full table-driven run, including a 50-cycle stall on digit 7.
    do_reset();
    for (int i = 0; i < MAX_DIGITS; i++) begin
      get_digit(tbl[i].digit, tbl[i].lat, tbl[i].hold, i + 1);
`ifdef SPIGOT_DIGIT_WINDOW_EN
      if (i == 3) chk("window4", int'(window), 32'h2718);
      if (i == 4) chk("window5", int'(window), 32'h7182);
`endif
    end
    for (int c = 0; c < 1000; c++) begin
      tick();
      chk("done_hold", int'(done), 1);
      chk("done_valid", int'(digit_valid), 0);
      chk("done_count", int'(digit_count), MAX_DIGITS);
    end

    // ena dropped for 20 cycles in the middle of the third digit's row.
    do_reset();
    get_digit(2, 1, 0, 1);
    get_digit(7, ROW_LAT, 0, 2);
    cyc = 0;
    repeat (60) begin
      tick();
      cyc++;
    end
    ena = 1'b0;
    repeat (20) begin
      tick();
      cyc++;
      chk("ena_low_valid", int'(digit_valid), 0);
    end
    ena = 1'b1;
    wait_valid(c2, ok);
    if (ok) begin
      chk("ena_drop_latency", cyc + c2, ROW_LAT + 20);
      chk("ena_drop_digit", int'(digit), 1);
      accept(3);
    end

    // Reset in the middle of the fourth digit's row restarts at 2.
    do_reset();
    get_digit(2, 1, 0, 1);
    get_digit(7, ROW_LAT, 0, 2);
    get_digit(1, ROW_LAT, 0, 3);
    repeat (70) tick();
    reset = 1'b1;
    tick();
    chk("midreset_valid", int'(digit_valid), 0);
    chk("midreset_count", int'(digit_count), 0);
    reset = 1'b0;
    get_digit(2, 1, 0, 1);
    get_digit(7, ROW_LAT, 0, 2);

    // Randomized ena/ready against the model and the ena-high latency rule.
    do_reset();
    idx = 0;
    since = 0;
    vprev = 1'b0;
    dprev = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 30000 && !done_seen; c++) begin
      e_v = ($urandom_range(0, 3) != 0);
      r_v = ($urandom_range(0, 1) != 0);
      ena = e_v;
      digit_ready = r_v;
      tick();
      if (e_v) since++;
      if (vprev && r_v && e_v) begin
        chk("rnd_digit", dprev, model[idx]);
        idx++;
        chk("rnd_count", int'(digit_count), idx);
        since = 0;
      end else if (vprev) begin
        chk("rnd_hold_valid", int'(digit_valid), 1);
        chk("rnd_hold_digit", int'(digit), dprev);
      end else if (digit_valid) begin
        chk("rnd_latency", since, (idx == 0) ? 1 : ROW_LAT);
      end else begin
        chk("rnd_count_idle", int'(digit_count), idx);
      end
      if (done) done_seen = 1'b1;
      vprev = digit_valid;
      dprev = int'(digit);
    end
    chk("rnd_done", int'(done), 1);
    chk("rnd_total", idx, MAX_DIGITS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
